// File: rtl/div_sequencer.sv
// Sequential RV64M divide/remainder controller: restoring shift-subtract, one
// quotient bit per cycle, driving a shared 64-bit adder/subtractor.

module arithmetic_unit #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            AddnSub,
   input  logic            ExtWord,
   output logic [XLEN-1:0] AddY,
   output logic            Cout
);
   logic [XLEN:0] sum;

   always_comb begin
      sum  = {1'b0, A} + {1'b0, (AddnSub ? ~B : B)} + {{XLEN{1'b0}}, AddnSub};
      Cout = sum[XLEN];
      AddY = ExtWord ? {{(XLEN-32){sum[31]}}, sum[31:0]} : sum[XLEN-1:0];
   end
endmodule

module div_sequencer #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] y
);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t          state, nstate;
   logic [1:0]      op_r;
   logic            word_r;
   logic [XLEN-1:0] a_r, b_r;
   logic [XLEN-1:0] rem_r, quo_r, div_r;
   logic [5:0]      cnt;
   logic            sa_r, sb_r;

   logic            sgn, neg_a, neg_b, dz, ovf, take, cout;
   logic [XLEN-1:0] ea, eb, abs_a, abs_b, s, addy, q_fix, r_fix, res, special;

   function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] v);
      return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
   endfunction

   arithmetic_unit #(.XLEN(XLEN)) u_au (
      .A       (s),
      .B       (div_r),
      .AddnSub (1'b1),
      .ExtWord (1'b0),
      .AddY    (addy),
      .Cout    (cout)
   );

   // Operand conditioning and result selection, all from latched operands.
   always_comb begin
      sgn     = ~op_r[0];
      ea      = word_r ? {{(XLEN-32){sgn & a_r[31]}}, a_r[31:0]} : a_r;
      eb      = word_r ? {{(XLEN-32){sgn & b_r[31]}}, b_r[31:0]} : b_r;
      neg_a   = sgn & ea[XLEN-1];
      neg_b   = sgn & eb[XLEN-1];
      abs_a   = neg_a ? -ea : ea;
      abs_b   = neg_b ? -eb : eb;
      dz      = (eb == '0);
      ovf     = sgn && (eb == '1) &&
                (ea == (word_r ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      special = dz ? (op_r[1] ? ea : '1) : (op_r[1] ? '0 : ea);
      s       = {rem_r[XLEN-2:0], (word_r ? quo_r[31] : quo_r[XLEN-1])};
      take    = rem_r[XLEN-1] | cout;
      q_fix   = (sa_r ^ sb_r) ? -quo_r : quo_r;
      r_fix   = sa_r ? -rem_r : rem_r;
      res     = op_r[1] ? r_fix : q_fix;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (start) nstate = PREP;
         PREP:    nstate = (dz || ovf) ? DONE : ITER;
         ITER:    if (cnt == 6'd0) nstate = FIX;
         FIX:     nstate = DONE;
         DONE:    nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_r   <= '0;
         word_r <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         rem_r  <= '0;
         quo_r  <= '0;
         div_r  <= '0;
         cnt    <= '0;
         sa_r   <= 1'b0;
         sb_r   <= 1'b0;
         y      <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_r   <= op;
               word_r <= word;
               a_r    <= a;
               b_r    <= b;
            end
            PREP: begin
               sa_r <= neg_a;
               sb_r <= neg_b;
               if (dz || ovf) begin
                  y <= wext(word_r, special);
               end else begin
                  rem_r <= '0;
                  quo_r <= abs_a;
                  div_r <= abs_b;
                  cnt   <= word_r ? 6'd31 : 6'd63;
               end
            end
            ITER: begin
               rem_r <= take ? addy : s;
               quo_r <= {quo_r[XLEN-2:0], take};
               if (cnt != 6'd0) cnt <= cnt - 6'd1;
            end
            FIX:     y <= wext(word_r, res);
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed RV64M cases, handshake/reset
// behaviour and a few random operations checked against a behavioural model.

module tb_div_sequencer;
   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic        word;
   logic [63:0] a, b;
   logic        busy, done;
   logic [63:0] y;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] yq[$];
   int          lq[$];

   div_sequencer #(.XLEN(64)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .word  (word),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model_y(input logic [1:0] o, input logic w,
                                           input logic [63:0] x, input logic [63:0] d);
      logic signed [31:0] sx32, sd32;
      logic signed [63:0] sx, sd;
      logic [31:0] r32;
      logic [63:0] r;
      sx32 = x[31:0];
      sd32 = d[31:0];
      sx   = x;
      sd   = d;
      if (w) begin
         if (d[31:0] == 32'd0) r32 = o[1] ? x[31:0] : 32'hFFFF_FFFF;
         else if (!o[0] && x[31:0] == 32'h8000_0000 && d[31:0] == 32'hFFFF_FFFF)
            r32 = o[1] ? 32'd0 : x[31:0];
         else begin
            case (o)
               2'd0:    r32 = sx32 / sd32;
               2'd1:    r32 = x[31:0] / d[31:0];
               2'd2:    r32 = sx32 % sd32;
               default: r32 = x[31:0] % d[31:0];
            endcase
         end
         r = {{32{r32[31]}}, r32};
      end else begin
         if (d == 64'd0) r = o[1] ? x : '1;
         else if (!o[0] && x == 64'h8000_0000_0000_0000 && d == '1)
            r = o[1] ? 64'd0 : x;
         else begin
            case (o)
               2'd0:    r = sx / sd;
               2'd1:    r = x / d;
               2'd2:    r = sx % sd;
               default: r = x % d;
            endcase
         end
      end
      return r;
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic w,
                                    input logic [63:0] x, input logic [63:0] d);
      if (w) begin
         if (d[31:0] == 32'd0) return 2;
         if (!o[0] && x[31:0] == 32'h8000_0000 && d[31:0] == 32'hFFFF_FFFF) return 2;
         return 35;
      end
      if (d == 64'd0) return 2;
      if (!o[0] && x == 64'h8000_0000_0000_0000 && d == '1) return 2;
      return 67;
   endfunction

   // Called at a negedge; start is raised immediately so consecutive calls
   // exercise the earliest possible re-accept. inj>0 pulses a stray start then.
   task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                         input logic [63:0] aa, input logic [63:0] bb,
                         input logic [63:0] ey, input int elat, input int inj);
      int cyc, busy_cnt;
      logic got_done;
      logic [63:0] exp_y;
      int exp_lat;
      yq.push_back(ey);
      lq.push_back(elat);
      start = 1'b1; op = o; word = w; a = aa; b = bb;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; busy_cnt = 0; got_done = 1'b0;
      while (!got_done && cyc < 200) begin
         if (busy) busy_cnt++;
         if (done) got_done = 1'b1;
         else begin
            start = (cyc == inj);
            if (cyc == inj) begin
               a = ~aa;
               b = 64'd1;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start   = 1'b0;
      exp_y   = yq.pop_front();
      exp_lat = lq.pop_front();
      check({tag, ".done_seen"}, 64'(got_done), 64'd1);
      check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, ".y"}, y, exp_y);
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      @(negedge clk);
      check({tag, ".done_after"}, 64'(done), 64'd0);
      check({tag, ".busy_after"}, 64'(busy), 64'd0);
      check({tag, ".y_held"}, y, exp_y);
   endtask

   initial begin
      int dcount;
      logic [1:0]  ro;
      logic        rw;
      logic [63:0] ra, rb;

      reset = 1'b1; start = 1'b0; op = '0; word = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("rst.busy", 64'(busy), 64'd0);
      check("rst.done", 64'(done), 64'd0);
      check("rst.y", y, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op("divu",   2'd1, 1'b0, 64'd100, 64'd7, 64'd14, 67, 0);
      run_op("remu",   2'd3, 1'b0, 64'd100, 64'd7, 64'd2,  67, 0);
      run_op("div_n",  2'd0, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 0);
      run_op("rem_n",  2'd2, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, 0);
      run_op("rem_p",  2'd2, 1'b0, 64'd7, -64'sd2, 64'd1, 67, 0);
      run_op("divu_z", 2'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
      run_op("remu_z", 2'd3, 1'b0, 64'd5, 64'd0, 64'd5, 2, 0);
      run_op("div_ov", 2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, 0);
      run_op("rem_ov", 2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
      run_op("divuw",  2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
      run_op("divw_ov", 2'd0, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2, 0);
      run_op("ignore", 2'd1, 1'b0, 64'd1000, 64'd10, 64'd100, 67, 10);

      // Abort mid-operation.
      start = 1'b1; op = 2'd1; word = 1'b0; a = 64'd12345; b = 64'd3;
      @(negedge clk);
      start = 1'b0;
      dcount = 0;
      for (int c = 1; c < 20; c++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort.busy", 64'(busy), 64'd0);
      check("abort.y", y, 64'd0);
      check("abort.done", 64'(done), 64'd0);
      for (int c = 0; c < 70; c++) begin
         if (done) dcount++;
         @(negedge clk);
      end
      check("abort.no_done", 64'(dcount), 64'd0);

      run_op("after_rst", 2'd0, 1'b0, 64'd100, -64'sd7, -64'sd14, 67, 0);

      for (int i = 0; i < 8; i++) begin
         ro = 2'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         ra = {$urandom, $urandom};
         rb = (i % 2 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
         if (i % 4 == 1) rb = -rb;
         run_op($sformatf("rand%0d", i), ro, rw, ra, rb,
                model_y(ro, rw, ra, rb), model_lat(ro, rw, ra, rb), 0);
      end

      // Reset coincident with start: nothing accepted.
      reset = 1'b1; start = 1'b1; op = 2'd1; word = 1'b0; a = 64'd9; b = 64'd3;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("rst_start.busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("rst_start.busy2", 64'(busy), 64'd0);
      check("rst_start.done", 64'(done), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
